tft_region_scheduler: RTL
=========================

Name: tft_region_scheduler

Overview:
- Shares the ILI9341 byte link between N_REQ requesters, each asking for a rectangular framebuffer region to be redrawn (for example the camera feed and the digit-detector overlay).
- For each granted region it sends CASET (0x2A) and PASET (0x2B) with the rectangle bounds, then RAMWR (0x2C).
- It then streams the region's pixels from the framebuffer, high byte first, over the same 9-bit {dc, byte} link used by the panel SPI engine.
- It sits between the requesters, the framebuffer RAM and tft_ili9341_spi, and runs after panel init is complete.

Parameters:
- WIDTH, 320, panel columns; x coordinates are 0..WIDTH-1.
- HEIGHT, 240, panel rows; y coordinates are 0..HEIGHT-1.
- N_REQ, 2, number of requesters.
- FB_AW, 17, framebuffer address width; must satisfy 2^FB_AW >= WIDTH*HEIGHT.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- init_done  in  1  panel init sequence finished; no grant is issued while low.
- req_valid  in  N_REQ  per-requester region request, held until accepted.
- req_x0, req_x1  in  N_REQ*9  inclusive column bounds, packed per requester.
- req_y0, req_y1  in  N_REQ*8  inclusive row bounds, packed per requester.
- req_ready  out  N_REQ  one-cycle accept pulse (one-hot).
- req_done  out  N_REQ  one-cycle completion pulse (one-hot).
- req_err  out  1  qualifies req_done: the region was rejected and nothing was sent.
- spi_data  out  9  {dc, byte}; dc=0 means command, dc=1 means data.
- spi_data_set  out  1  one-cycle strobe that loads spi_data into the SPI engine.
- spi_idle  in  1  SPI engine ready for a byte.
- fb_rd  out  1  framebuffer read strobe.
- fb_addr  out  FB_AW  pixel index y*WIDTH+x.
- fb_data  in  16  RGB565 pixel, valid exactly one cycle after fb_rd.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n low): state=IDLE and every output is 0: req_ready, req_done, req_err, spi_data, spi_data_set, fb_rd, fb_addr, busy. The round-robin pointer resets to requester 0. Asserting reset mid-region aborts the transfer immediately with no done pulse.
- Byte issue rule: a byte is launched only in a cycle where spi_idle=1 and spi_data_set was 0 in the previous cycle. spi_idle lags the strobe by one cycle. At most one strobe is ever outstanding.
- Arbitration:
  - In IDLE with init_done=1, grant the first requester with req_valid set, searching round-robin from the one after the last grant.
  - req_ready pulses in the grant cycle, and the x0/x1/y0/y1 for that requester are latched.
  - A request that appears during a busy region waits; it is never dropped.
- Validation: a region is rejected if x0>x1, y0>y1, x1>=WIDTH or y1>=HEIGHT.
  - For a rejected region, req_done and req_err pulse the cycle after req_ready. No SPI traffic is generated; return to IDLE.
- State sequence for a valid region: IDLE -> CASET -> PASET -> RAMWR -> FETCH -> PIX_HI -> PIX_LO -> (FETCH or FINISH) -> IDLE.
  - CASET: command {0,0x2A}, then data {1,x0[15:8]}, {1,x0[7:0]}, {1,x1[15:8]}, {1,x1[7:0]}; coordinates are zero-extended to 16 bits.
  - PASET: command {0,0x2B}, then four data bytes for y0 and y1, in the same layout.
  - RAMWR: command {0,0x2C}. On leaving RAMWR, fb_addr = y0*WIDTH + x0. The multiply happens once per region and may be pipelined over 2 cycles.
  - FETCH: fb_rd high for exactly one cycle. fb_data is captured into the pixel register on the next cycle.
  - PIX_HI: send {1,pix[15:8]}.
  - PIX_LO: send {1,pix[7:0]}.
- Address and counter update after PIX_LO:
  - If x<x1: x+1, fb_addr+1.
  - Else if y<y1: x=x0, y+1, fb_addr += WIDTH-(x1-x0).
  - Else go to FINISH.
- FINISH: req_done pulses for one cycle for the granted requester, with req_err=0.
- Single-pixel region (x0=x1, y0=y1): exactly 11 command/data bytes plus 2 pixel bytes.
- A full-screen region is 320*240 pixels, i.e. 153600 pixel bytes; counters must not overflow.
- init_done falling mid-region: the current region still completes. No new grant is issued until init_done is high again.
- A requester whose req_valid stays high after completion is re-queued normally. Round-robin guarantees the other requester is granted first if it is also waiting.

Decomposition:
- Package tft_pkg: holds the command constants CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C, the state enum type, and a rect_t struct {x0,x1,y0,y1}.
- One natural sub-module, tft_rr_arbiter: an N_REQ round-robin grant with a last-grant pointer. It is purely request/grant, with no knowledge of the panel.

Test Plan:
- Single pixel: req0 with (5,5,7,7), spi_idle always 1 -> bytes 02A 000 005 000 005 02B 000 007 000 007 02C; fb_addr=2245 with fb_data=16'hF81F -> 1F8 11F; then req_done[0] pulses with req_err=0.
- Row wrap: req1 with x 318..319, y 0..1 -> fb_addr sequence 318, 319, 638, 639; exactly 8 pixel bytes; then done[1].
- Arbitration: req0 and req1 both held valid continuously -> grants alternate 0, 1, 0, 1; neither requester is granted twice in a row.
- Backpressure: spi_idle low for 3 cycles after each strobe -> byte order is unchanged, spi_data_set is never asserted in two consecutive cycles, and no byte is lost or duplicated.
- Rejects: x0=10 with x1=4, and separately y1=240 -> req_ready, then req_done with req_err=1 the next cycle, and zero spi_data_set pulses.
- Reset and init gating: rst_n low during the PASET data bytes -> all outputs 0 immediately. After release with init_done=0, no grant occurs; with init_done=1, a fresh CASET starts.

Source files
------------

// File: rtl/tft_pkg.sv
// Shared definitions for the TFT region scheduler.
// Holds the ILI9341 window/write command bytes, the scheduler state type,
// the latched region rectangle and a helper that picks one coordinate byte
// out of a CASET/PASET data burst.
package tft_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_FETCH,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_FINISH,
    ST_REJECT
  } state_t;

  typedef struct packed {
    logic [8:0] x0;
    logic [8:0] x1;
    logic [7:0] y0;
    logic [7:0] y1;
  } rect_t;

  // Byte 0 of a window burst is the command; bytes 1..4 are start-high,
  // start-low, end-high, end-low of the 16-bit zero-extended bounds.
  function automatic logic [7:0] coord_byte(input logic [15:0] first,
                                            input logic [15:0] last,
                                            input logic [2:0]  idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd1: b = first[15:8];
      3'd2: b = first[7:0];
      3'd3: b = last[15:8];
      3'd4: b = last[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tft_rr_arbiter.sv
// Round-robin request/grant arbiter.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   en           grant permitted this cycle
//   req          per-requester request vector
//   grant        one-hot grant (combinational, only while en)
//   grant_idx    index of the granted requester
//   grant_valid  a grant is being issued this cycle
// The search starts at ptr, which always names the requester after the
// most recent grant, so a continuously asserted requester cannot starve
// another one.
module tft_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             grant_valid
);

  logic [IW-1:0] ptr;

  function automatic int wrap_idx(input int v);
    return (v >= N_REQ) ? v - N_REQ : v;
  endfunction

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (en && !grant_valid && req[wrap_idx(int'(ptr) + i)]) begin
        grant_valid                      = 1'b1;
        grant_idx                        = IW'(wrap_idx(int'(ptr) + i));
        grant[wrap_idx(int'(ptr) + i)]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/tft_region_scheduler.sv
// Region redraw scheduler for an ILI9341 panel.
// Grants one requester at a time, sends CASET/PASET/RAMWR for its
// rectangle, then streams the rectangle's RGB565 pixels (high byte first)
// from the framebuffer over the 9-bit {dc, byte} SPI engine link.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   init_done                  panel init finished; gates new grants
//   req_valid                  per-requester region request
//   req_x0/x1, req_y0/y1       packed inclusive bounds per requester
//   req_ready, req_done        one-hot accept / completion pulses
//   req_err                    qualifies req_done for a rejected region
//   spi_data, spi_data_set     byte to SPI engine and its load strobe
//   spi_idle                   SPI engine can take a byte
//   fb_rd, fb_addr, fb_data    framebuffer read port (1-cycle latency)
//   busy                       not idle
module tft_region_scheduler
  import tft_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int N_REQ  = 2,
  parameter int FB_AW  = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_done,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*9-1:0] req_x0,
  input  logic [N_REQ*9-1:0] req_x1,
  input  logic [N_REQ*8-1:0] req_y0,
  input  logic [N_REQ*8-1:0] req_y1,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   req_done,
  output logic               req_err,
  output logic [8:0]         spi_data,
  output logic               spi_data_set,
  input  logic               spi_idle,
  output logic               fb_rd,
  output logic [FB_AW-1:0]   fb_addr,
  input  logic [15:0]        fb_data,
  output logic               busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [FB_AW-1:0] W_A = FB_AW'(WIDTH);

  state_t        state, state_next;
  rect_t         rect, req_rect;
  logic [IW-1:0] cur;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic          req_ok;
  logic          can_send;
  logic          prev_set;
  logic          pix_loaded;
  logic [2:0]    idx;
  logic [8:0]    x;
  logic [7:0]    y;
  logic [15:0]   pix;
  logic [FB_AW-1:0] start_addr;
  logic [FB_AW-1:0] wrap_add;

  tft_rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (state == ST_IDLE && init_done),
    .req         (req_valid),
    .grant       (req_ready),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Rectangle of the requester being granted, and its validity.
  always_comb begin
    req_rect.x0 = req_x0[grant_idx*9 +: 9];
    req_rect.x1 = req_x1[grant_idx*9 +: 9];
    req_rect.y0 = req_y0[grant_idx*8 +: 8];
    req_rect.y1 = req_y1[grant_idx*8 +: 8];
    req_ok = (req_rect.x0 <= req_rect.x1) && (req_rect.y0 <= req_rect.y1) &&
             (32'(req_rect.x1) < WIDTH) && (32'(req_rect.y1) < HEIGHT);
  end

  assign start_addr = FB_AW'(rect.y0) * W_A + FB_AW'(rect.x0);
  // Moving from the last column of a row to the first column of the next.
  assign wrap_add   = W_A - FB_AW'(rect.x1 - rect.x0);

  // One strobe outstanding at most: the engine only reports idle a cycle
  // after it is loaded, so the cycle after a strobe is never usable.
  assign can_send = spi_idle && !prev_set;
  assign busy     = (state != ST_IDLE);
  assign req_err  = (state == ST_REJECT);

  always_comb begin
    req_done = '0;
    if (state == ST_FINISH || state == ST_REJECT) req_done[cur] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    spi_data     = 9'h000;
    spi_data_set = 1'b0;
    fb_rd        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) state_next = req_ok ? ST_CASET : ST_REJECT;
      end
      ST_REJECT: state_next = ST_IDLE;
      ST_CASET: begin
        spi_data = (idx == 3'd0) ? {1'b0, CMD_CASET}
                 : {1'b1, coord_byte(16'(rect.x0), 16'(rect.x1), idx)};
        spi_data_set = can_send;
        if (can_send && idx == 3'd4) state_next = ST_PASET;
      end
      ST_PASET: begin
        spi_data = (idx == 3'd0) ? {1'b0, CMD_PASET}
                 : {1'b1, coord_byte(16'(rect.y0), 16'(rect.y1), idx)};
        spi_data_set = can_send;
        if (can_send && idx == 3'd4) state_next = ST_RAMWR;
      end
      ST_RAMWR: begin
        spi_data     = {1'b0, CMD_RAMWR};
        spi_data_set = can_send;
        if (can_send) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        fb_rd      = 1'b1;
        state_next = ST_PIX_HI;
      end
      // The first PIX_HI cycle is spent capturing fb_data.
      ST_PIX_HI: begin
        spi_data     = {1'b1, pix[15:8]};
        spi_data_set = can_send && pix_loaded;
        if (can_send && pix_loaded) state_next = ST_PIX_LO;
      end
      ST_PIX_LO: begin
        spi_data     = {1'b1, pix[7:0]};
        spi_data_set = can_send;
        if (can_send) begin
          state_next = (x < rect.x1 || y < rect.y1) ? ST_FETCH : ST_FINISH;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rect       <= '0;
      cur        <= '0;
      idx        <= '0;
      x          <= '0;
      y          <= '0;
      pix        <= '0;
      pix_loaded <= 1'b0;
      prev_set   <= 1'b0;
      fb_addr    <= '0;
    end else begin
      prev_set <= spi_data_set;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            rect <= req_rect;
            cur  <= grant_idx;
            idx  <= '0;
          end
        end
        ST_CASET, ST_PASET: begin
          if (spi_data_set) idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end
        ST_RAMWR: begin
          if (spi_data_set) begin
            fb_addr <= start_addr;
            x       <= rect.x0;
            y       <= rect.y0;
          end
        end
        ST_FETCH: pix_loaded <= 1'b0;
        ST_PIX_HI: begin
          if (!pix_loaded) begin
            pix        <= fb_data;
            pix_loaded <= 1'b1;
          end
        end
        ST_PIX_LO: begin
          if (spi_data_set) begin
            if (x < rect.x1) begin
              x       <= x + 9'd1;
              fb_addr <= fb_addr + FB_AW'(1);
            end else if (y < rect.y1) begin
              x       <= rect.x0;
              y       <= y + 8'd1;
              fb_addr <= fb_addr + wrap_add;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
